// File: rtl/issue_scoreboard.sv
// Purpose : register scoreboard + issue FSM between ID and EX_STATE; per-register
//           countdowns give a latency-accurate RAW/WAW interlock, and control
//           instructions block issue until EX resolves them (taken -> front-end flush).
// Latency : issue/stall/busy_mask are combinational from registered state and ID inputs;
//           flush is decoded from registered state only.
// Backpressure: stall = id_valid & !issue holds PC/ID and injects a NOP into EX_STATE.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   id_valid                   ID has an instruction ready to issue
//   id_rs1/rs2, id_rs*_used    source indices and whether each is actually read
//   id_rd, id_reg_write        destination and whether it is written
//   id_is_load                 destination becomes readable after LOAD_LAT instead of ALU_LAT
//   id_is_ctrl                 branch / JAL / JALR: issue blocks until EX resolves it
//   ex_resolve, ex_taken       one-cycle resolution pulse from EX, taken = PC redirect
//   issue, stall, flush        issue strobe, decode hold, IF/ID squash
//   busy_mask                  bit r set while register r still has a write in flight
module issue_scoreboard #(
    parameter int ALU_LAT   = 3,
    parameter int LOAD_LAT  = 4,
    parameter int FLUSH_LEN = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  id_rd,
    input  logic        id_reg_write,
    input  logic        id_is_load,
    input  logic        id_is_ctrl,
    input  logic        ex_resolve,
    input  logic        ex_taken,
    output logic        issue,
    output logic        stall,
    output logic        flush,
    output logic [31:0] busy_mask
);

    localparam int CW = $clog2(LOAD_LAT + 1);
    localparam int FW = (FLUSH_LEN < 1) ? 1 : $clog2(FLUSH_LEN + 1);

    localparam logic [CW-1:0] ALU_L  = CW'(ALU_LAT);
    localparam logic [CW-1:0] LOAD_L = CW'(LOAD_LAT);
    localparam logic [FW-1:0] FLEN   = FW'(FLUSH_LEN);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] fcnt_q, fcnt_d;

    // x0 is never tracked, so only 1..31 get counters.
    logic [CW-1:0] cnt_q [31:1];
    logic [CW-1:0] cnt_d [31:1];

    logic [31:0] busy;
    logic        raw;
    logic        waw;

    always_comb begin
        busy = '0;
        for (int r = 1; r < 32; r++) begin
            busy[r] = (cnt_q[r] != '0);
        end
    end

    assign busy_mask = busy;

    // busy[0] is constant 0, which covers the "index is x0" exclusions.
    assign raw = (id_rs1_used & busy[id_rs1]) | (id_rs2_used & busy[id_rs2]);
    assign waw = id_reg_write & busy[id_rd];

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        issue   = 1'b0;
        flush   = 1'b0;
        case (state_q)
            RUN: begin
                issue = id_valid & ~raw & ~waw;
                // A resolve pulse arriving while still in RUN (including the
                // cycle the control op issues) belongs to nothing and is dropped.
                if (issue && id_is_ctrl) begin
                    state_d = BR_WAIT;
                end
            end
            BR_WAIT: begin
                if (ex_resolve) begin
                    if (ex_taken) begin
                        state_d = FLUSH;
                        fcnt_d  = FLEN;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            FLUSH: begin
                flush  = 1'b1;
                fcnt_d = fcnt_q - FW'(1);
                // Leave on the last flush cycle so RUN starts exactly FLUSH_LEN
                // cycles after the redirect.
                if (fcnt_q <= FW'(1)) begin
                    state_d = RUN;
                    fcnt_d  = '0;
                end
            end
            default: begin
                state_d = RUN;
                fcnt_d  = '0;
            end
        endcase
        if (reset) begin
            issue = 1'b0;
            flush = 1'b0;
        end
    end

    // Outside RUN issue is 0, so this also holds ID and forces the NOP there.
    assign stall = id_valid & ~issue & ~reset;

    always_comb begin
        for (int r = 1; r < 32; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? (cnt_q[r] - CW'(1)) : cnt_q[r];
            // The WAW check guarantees the old value is already 0 here.
            if (issue && id_reg_write && (id_rd == 5'(r))) begin
                cnt_d[r] = id_is_load ? LOAD_L : ALU_L;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            for (int r = 1; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            for (int r = 1; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Purpose : self-checking bench for issue_scoreboard against a cycle-number model
//           (register ready times, branch-wait flag, resume/flush windows).
// Latency : one model step per clock; inputs driven on the falling edge.
// Backpressure: stall expected whenever a valid instruction does not issue.
module tb_issue_scoreboard;

    localparam int AL = 3;
    localparam int LL = 4;
    localparam int FL = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rs1_used, id_rs2_used, id_reg_write, id_is_load, id_is_ctrl;
    logic        ex_resolve, ex_taken;
    logic        issue, stall, flush;
    logic [31:0] busy_mask;

    issue_scoreboard #(.ALU_LAT(AL), .LOAD_LAT(LL), .FLUSH_LEN(FL)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .id_is_ctrl(id_is_ctrl), .ex_resolve(ex_resolve), .ex_taken(ex_taken),
        .issue(issue), .stall(stall), .flush(flush), .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: register r is readable from cycle ready_at[r] onward.
    int cyc;
    int ready_at [32];
    bit br_wait;
    int resume;     // first cycle issue is allowed again after a resolve
    int flush_end;  // last cycle of the flush window

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got %h exp %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
        br_wait   = 1'b0;
        resume    = 0;
        flush_end = -1;
    endtask

    function automatic bit busy_at(input logic [4:0] r);
        return (r != 5'd0) && (cyc < ready_at[r]);
    endfunction

    task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2, input logic [4:0] d,
                         input logic w, input logic ld, input logic ct,
                         input logic res, input logic tk);
        id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
        id_rd = d; id_reg_write = w; id_is_load = ld; id_is_ctrl = ct;
        ex_resolve = res; ex_taken = tk;
    endtask

    // One clock: drive, check against the model (and optionally a fixed issue value), advance.
    task automatic step(input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2, input logic [4:0] d,
                        input logic w, input logic ld, input logic ct,
                        input logic res, input logic tk, input int exp_iss);
        logic [31:0] eb;
        bit e_iss, e_flush, hazard;
        @(negedge clk);
        drive(v, r1, u1, r2, u2, d, w, ld, ct, res, tk);
        #1;
        eb = '0;
        for (int r = 1; r < 32; r++) eb[r] = busy_at(5'(r));
        hazard  = (u1 && busy_at(r1)) || (u2 && busy_at(r2)) || (w && busy_at(d));
        e_iss   = v && !br_wait && (cyc >= resume) && !hazard;
        e_flush = (cyc <= flush_end);
        chk("issue", 32'(issue), 32'(e_iss));
        chk("stall", 32'(stall), 32'(v && !e_iss));
        chk("flush", 32'(flush), 32'(e_flush));
        chk("busy_mask", busy_mask, eb);
        if (exp_iss >= 0) chk("issue_directed", 32'(issue), 32'(exp_iss));
        if (br_wait && res) begin
            br_wait = 1'b0;
            if (tk) begin
                flush_end = cyc + FL;
                resume    = cyc + FL + 1;
            end else begin
                resume = cyc + 1;
            end
        end
        if (e_iss) begin
            if (w && d != 5'd0) ready_at[d] = cyc + (ld ? LL : AL) + 1;
            if (ct) br_wait = 1'b1;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    endtask

    // Independent non-writing op, used as filler during stalls.
    task automatic nop_op(input int exp_iss, input logic res, input logic tk);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, res, tk, exp_iss);
    endtask

    initial begin
        cyc = 0;
        model_clear();
        reset = 1'b1;
        drive(1, 5'd5, 1, 5'd6, 1, 5'd7, 1, 0, 1, 1, 1);
        #2;
        chk("rst_issue", 32'(issue), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_busy", busy_mask, 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #4 reset = 1'b0;
        cyc++;

        // add x5 ; sub x6,x5,x1 -> 3 stalls, issue in cycle 4
        step(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 0, 0, 0);
            chk("busy5", 32'(busy_mask[5]), 32'd1);
        end
        step(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 0, 0, 1);
        idle(5);

        // lw x8 ; addi x9,x8,1 -> 4 stalls
        step(1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 5'd8, 1, 5'd0, 0, 5'd9, 1, 0, 0, 0, 0, 0);
        step(1, 5'd8, 1, 5'd0, 0, 5'd9, 1, 0, 0, 0, 0, 1);
        idle(5);

        // lw x8 ; addi x0,x0,0 (no stall) ; rs2=8 unused (no stall)
        step(1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 1, 0, 0, 0, 1);
        step(1, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 0, 0, 0, 1);
        step(1, 5'd1, 1, 5'd8, 0, 5'd10, 1, 0, 0, 0, 0, 1);
        idle(5);

        // WAW: lw x3 ; addi x3,x1,1 waits out cnt[3], then reloads ALU latency
        step(1, 5'd1, 1, 5'd0, 0, 5'd3, 1, 1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 5'd1, 1, 5'd0, 0, 5'd3, 1, 0, 0, 0, 0, 0);
        step(1, 5'd1, 1, 5'd0, 0, 5'd3, 1, 0, 0, 0, 0, 1);
        idle(1);
        chk("waw_reload_busy3", 32'(busy_mask[3]), 32'd1);
        idle(5);

        // Branch, not-taken resolve two cycles later
        step(1, 5'd1, 1, 5'd2, 1, 5'd0, 0, 0, 1, 0, 0, 1);
        nop_op(0, 0, 0);
        nop_op(0, 1, 0);
        nop_op(1, 0, 0);
        idle(2);

        // Branch, taken resolve next cycle; second resolve during flush ignored
        step(1, 5'd1, 1, 5'd2, 1, 5'd0, 0, 0, 1, 0, 0, 1);
        nop_op(0, 1, 1);
        nop_op(0, 1, 0);
        nop_op(0, 0, 0);
        nop_op(1, 0, 0);
        idle(2);

        // Reset mid-FLUSH with cnt[7]=2: JAL x7, taken resolve, then reset
        step(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 1, 0, 0, 1);
        nop_op(0, 1, 1);
        @(negedge clk);
        drive(1, 5'd7, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0);
        #1;
        chk("pre_rst_flush", 32'(flush), 32'd1);
        chk("pre_rst_busy7", 32'(busy_mask[7]), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_flush", 32'(flush), 32'd0);
        chk("mid_rst_busy", busy_mask, 32'd0);
        chk("mid_rst_issue", 32'(issue), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        #2;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        model_clear();
        cyc++;
        step(1, 5'd7, 1, 5'd0, 0, 5'd11, 1, 0, 0, 0, 0, 1);
        idle(5);

        // Randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 8,
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 1,
                 $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
